// File: rtl/qar_mem_arbiter.sv
// Two-port (fetch/data) to one-port memory arbiter with data-first priority,
// a fetch starvation guard, and atomic grant-to-response transactions.
module qar_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // Fetch port
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ready,
    output logic [31:0]           i_rdata,
    // Data port
    input  logic                  d_valid,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_ready,
    output logic [31:0]           d_rdata,
    // Downstream memory bus
    output logic                  m_valid,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]           m_wdata,
    input  logic                  m_ready,
    input  logic [31:0]           m_rdata,
    output logic [1:0]            grant
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] GrantI    = 2'b01;
    localparam logic [1:0] GrantD    = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StRespI,
        StRespD
    } state_e;

    state_e                r_state, w_state_d;
    logic [CntW-1:0]       r_starve_cnt, w_starve_cnt_d;
    logic                  r_m_valid, w_m_valid_d;
    logic                  r_m_we, w_m_we_d;
    logic [ADDR_WIDTH-1:0] r_m_addr, w_m_addr_d;
    logic [31:0]           r_m_wdata, w_m_wdata_d;
    logic                  r_i_ready, w_i_ready_d;
    logic [31:0]           r_i_rdata, w_i_rdata_d;
    logic                  r_d_ready, w_d_ready_d;
    logic [31:0]           r_d_rdata, w_d_rdata_d;
    logic [1:0]            r_grant, w_grant_d;
    logic                  w_data_wins;

    // Data wins unless a fetch is waiting and has already been passed over too often.
    assign w_data_wins = d_valid && (!i_valid || (r_starve_cnt < Limit));

    always_comb begin
        w_state_d      = r_state;
        w_starve_cnt_d = r_starve_cnt;
        w_m_valid_d    = r_m_valid;
        w_m_we_d       = r_m_we;
        w_m_addr_d     = r_m_addr;
        w_m_wdata_d    = r_m_wdata;
        w_i_ready_d    = 1'b0;
        w_i_rdata_d    = r_i_rdata;
        w_d_ready_d    = 1'b0;
        w_d_rdata_d    = r_d_rdata;
        w_grant_d      = r_grant;

        unique case (r_state)
            StIdle: begin
                w_m_valid_d = 1'b0;
                w_grant_d   = GrantNone;
                if (w_data_wins) begin
                    w_state_d   = StBusyD;
                    w_m_valid_d = 1'b1;
                    w_grant_d   = GrantD;
                    w_m_we_d    = d_we;
                    w_m_addr_d  = d_addr;
                    w_m_wdata_d = d_wdata;
                    if (i_valid) begin
                        w_starve_cnt_d = (r_starve_cnt == Limit) ? r_starve_cnt
                                                                 : r_starve_cnt + CntW'(1);
                    end else begin
                        w_starve_cnt_d = '0;
                    end
                end else if (i_valid) begin
                    w_state_d      = StBusyI;
                    w_m_valid_d    = 1'b1;
                    w_grant_d      = GrantI;
                    w_m_we_d       = 1'b0;
                    w_m_addr_d     = i_addr;
                    w_m_wdata_d    = '0;
                    w_starve_cnt_d = '0;
                end
            end
            StBusyI: begin
                if (m_ready) begin
                    w_state_d   = StRespI;
                    w_i_rdata_d = m_rdata;
                    w_i_ready_d = 1'b1;
                    w_m_valid_d = 1'b0;
                    w_grant_d   = GrantNone;
                end
            end
            StBusyD: begin
                if (m_ready) begin
                    w_state_d   = StRespD;
                    if (!r_m_we) begin
                        w_d_rdata_d = m_rdata;
                    end
                    w_d_ready_d = 1'b1;
                    w_m_valid_d = 1'b0;
                    w_grant_d   = GrantNone;
                end
            end
            StRespI, StRespD: begin
                // Requester valid here still belongs to the completed request.
                w_state_d   = StIdle;
                w_m_valid_d = 1'b0;
                w_grant_d   = GrantNone;
            end
            default: begin
                w_state_d   = StIdle;
                w_m_valid_d = 1'b0;
                w_grant_d   = GrantNone;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_starve_cnt <= '0;
            r_m_valid    <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_i_ready    <= 1'b0;
            r_i_rdata    <= '0;
            r_d_ready    <= 1'b0;
            r_d_rdata    <= '0;
            r_grant      <= GrantNone;
        end else begin
            r_state      <= w_state_d;
            r_starve_cnt <= w_starve_cnt_d;
            r_m_valid    <= w_m_valid_d;
            r_m_we       <= w_m_we_d;
            r_m_addr     <= w_m_addr_d;
            r_m_wdata    <= w_m_wdata_d;
            r_i_ready    <= w_i_ready_d;
            r_i_rdata    <= w_i_rdata_d;
            r_d_ready    <= w_d_ready_d;
            r_d_rdata    <= w_d_rdata_d;
            r_grant      <= w_grant_d;
        end
    end

    assign i_ready = r_i_ready;
    assign i_rdata = r_i_rdata;
    assign d_ready = r_d_ready;
    assign d_rdata = r_d_rdata;
    assign m_valid = r_m_valid;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign grant   = r_grant;

endmodule
